// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers; all outputs registered.
// Optional WAIT_BUSY timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           tx_p_data,
    output logic                            tx_data_valid,
    input  logic                            tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            active,
    output logic                            timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            grant;
    int              idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_CNT_W-1:0] to_cnt;
    logic                timeout_hit;
`endif

    // Scan from ptr+1 upward with wrap, so the last winner has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign grant = (state == IDLE) && found && !tx_busy;

    always_comb begin
        state_nxt = state;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE:      if (grant) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            ack           <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            active        <= 1'b0;
        end else begin
            state         <= state_nxt;
            active        <= (state_nxt != IDLE);
            tx_data_valid <= grant;
            ack           <= '0;
            if (grant) begin
                ack[winner] <= 1'b1;
                tx_p_data   <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                grant_id    <= winner;
                ptr         <= winner;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Counter restarts on every entry into WAIT_BUSY.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state == WAIT_BUSY && state_nxt == WAIT_BUSY)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a round-robin reference model.
module tb_uart_tx_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int mptr;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_p_data(tx_p_data),
        .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: first pending requester after the last winner, wrapping around.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    task automatic check_idle_outputs_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_valid"}, 32'(tx_data_valid), 0);
        check({tag, "_pdata"}, 32'(tx_p_data), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_tmo"}, 32'(timeout_err), 0);
    endtask

    // One full frame: grant on next edge, UART busy for busy_len cycles, back to IDLE.
    task automatic grant_frame(input int busy_len, input bit keep_req, input bit scramble,
                               input string tag);
        int         w;
        logic [7:0] b;
        w = rr_pick(req, mptr);
        b = req_data[w*8 +: 8];
        step();
        check({tag, "_valid"}, 32'(tx_data_valid), 1);
        check({tag, "_ack"}, 32'(ack), 32'd1 << w);
        check({tag, "_gid"}, 32'(grant_id), 32'(w));
        check({tag, "_pdata"}, 32'(tx_p_data), 32'(b));
        check({tag, "_active"}, 32'(active), 1);
        mptr = w;
        if (!keep_req) req[w] = 1'b0;
        if (scramble) req_data = $urandom;
        tx_busy = 1'b1;
        step();
        check({tag, "_ack_pulse"}, 32'(ack), 0);
        check({tag, "_valid_pulse"}, 32'(tx_data_valid), 0);
        repeat (busy_len) step();
        check({tag, "_busy_active"}, 32'(active), 1);
        check({tag, "_hold_pdata"}, 32'(tx_p_data), 32'(b));
        tx_busy = 1'b0;
        step();
        check({tag, "_done_active"}, 32'(active), 0);
        check({tag, "_done_pdata"}, 32'(tx_p_data), 32'(b));
    endtask

    initial begin
        int exp_order[5];
        int gate;
        exp_order = '{0, 1, 2, 3, 0};

        RST      = 1'b0;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        mptr     = 3;
        repeat (3) step();
        check_idle_outputs_zero("reset");
        RST = 1'b1;
        step();

        // Single requester.
        req = 4'b0100;
        req_data[2*8 +: 8] = 8'hA5;
        grant_frame(10, 1'b0, 1'b0, "single");
        check("single_gid2", 32'(grant_id), 2);
        step();
        check("single_quiet", 32'(tx_data_valid), 0);

        // Round-robin across all four from a fresh reset.
        RST = 1'b0;
        step();
        RST  = 1'b1;
        mptr = 3;
        req  = 4'b1111;
        req_data = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            grant_frame(3, 1'b1, 1'b0, "rr");
            check("rr_order", 32'(grant_id), 32'(exp_order[k]));
        end
        req = '0;

        // Wrap from pointer 3 back to requester 0.
        req = 4'b1000;
        grant_frame(2, 1'b0, 1'b0, "wrap_set");
        req = 4'b1001;
        req_data = 32'hC3_00_00_3C;
        grant_frame(2, 1'b1, 1'b0, "wrap_a");
        check("wrap_first0", 32'(grant_id), 0);
        grant_frame(2, 1'b1, 1'b0, "wrap_b");
        check("wrap_then3", 32'(grant_id), 3);
        req = '0;

        // Busy gate while idle.
        tx_busy = 1'b1;
        req = 4'b0001;
        req_data[7:0] = 8'h5A;
        repeat (4) begin
            step();
            check("gate_valid", 32'(tx_data_valid), 0);
            check("gate_active", 32'(active), 0);
        end
        tx_busy = 1'b0;
        grant_frame(3, 1'b0, 1'b0, "gate");

        // Timeout: busy never rises.
        req = 4'b0010;
        req_data[15:8] = 8'h77;
        step();
        check("tmo_valid", 32'(tx_data_valid), 1);
        check("tmo_gid", 32'(grant_id), 1);
        mptr = 1;
        req  = '0;
        step();
        repeat (63) begin
            step();
            check("tmo_early", 32'(timeout_err), 0);
        end
        step();
`ifdef UART_ARB_TIMEOUT_EN
        check("tmo_pulse", 32'(timeout_err), 1);
        check("tmo_idle", 32'(active), 0);
        step();
        check("tmo_pulse_end", 32'(timeout_err), 0);
`else
        check("tmo_none", 32'(timeout_err), 0);
        check("tmo_waiting", 32'(active), 1);
`endif
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        step();
        check("tmo_recover", 32'(active), 0);

        // Reset during WAIT_DONE.
        req = 4'b0100;
        req_data[23:16] = 8'hE1;
        step();
        check("rst_grant", 32'(grant_id), 2);
        req     = '0;
        tx_busy = 1'b1;
        step();
        step();
        check("rst_in_frame", 32'(active), 1);
        RST = 1'b0;
        #1;
        check_idle_outputs_zero("rst_mid");
        mptr = 3;
        req  = 4'b0010;
        req_data[15:8] = 8'h42;
        step();
        RST = 1'b1;
        repeat (2) begin
            step();
            check("rst_busy_gate", 32'(tx_data_valid), 0);
        end
        tx_busy = 1'b0;
        grant_frame(2, 1'b0, 1'b0, "rst_after");
        check("rst_gid1", 32'(grant_id), 1);
        req = '0;

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            req      = 4'($urandom_range(1, 15));
            req_data = $urandom;
            gate     = $urandom_range(0, 3);
            if (gate > 0) begin
                tx_busy = 1'b1;
                repeat (gate) begin
                    step();
                    check("rnd_gate", 32'(tx_data_valid), 0);
                end
                tx_busy = 1'b0;
            end
            grant_frame($urandom_range(1, 6), 1'b0, 1'($urandom_range(0, 1)), "rnd");
            req = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
